// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the traffic-light front end and controller benches.
//   - demand_state_e : per-approach demand FSM encoding
//   - DEBOUNCE_CYCLES_DEF / WAIT_W_DEF : default parameter values
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEMAND = 2'd1,
    ST_SERVED = 2'd2
  } demand_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int WAIT_W_DEF          = 8;

endpackage : traffic_pkg

// File: rtl/approach_demand.sv
// -----------------------------------------------------------------------------
// approach_demand
//   One traffic approach: synchronises and debounces a raw loop sensor,
//   latches the vehicle demand until the controller shows green, and counts
//   how long a latched demand has waited (saturating).
// Ports
//   i_clk     in   1       system clock, rising edge
//   i_rst_n   in   1       synchronous reset, active low
//   i_loop    in   1       raw loop sensor (asynchronous, may bounce)
//   i_green   in   1       green indication fed back from the controller
//   o_detect  out  1       demand to the controller
//   o_wait    out  WAIT_W  cycles spent in DEMAND, saturating; 0 otherwise
// -----------------------------------------------------------------------------
module approach_demand
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WAIT_W          = WAIT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_loop,
  input  logic              i_green,
  output logic              o_detect,
  output logic [WAIT_W-1:0] o_wait
);

  // Counter must reach DEBOUNCE_CYCLES-1; one spare value keeps width >= 1.
  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]        sync_q,  sync_d;
  logic              deb_q,   deb_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  demand_state_e     state_q, state_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;

  logic              loop_s;

  // Second stage of the synchroniser is the only safe view of the sensor.
  assign loop_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sync_d  = {sync_q[0], i_loop};
    deb_d   = deb_q;
    cnt_d   = '0;
    state_d = state_q;
    wait_d  = '0;

    // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    if (loop_s != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Demand FSM works on the registered debounced level.
    unique case (state_q)
      ST_IDLE: begin
        if (deb_q) begin
          state_d = i_green ? ST_SERVED : ST_DEMAND;
        end
      end
      ST_DEMAND: begin
        // Vehicle leaving the loop does not cancel a latched demand.
        if (i_green) begin
          state_d = ST_SERVED;
        end
      end
      ST_SERVED: begin
        if (!i_green) begin
          state_d = deb_q ? ST_DEMAND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Wait counter: zero on entry to DEMAND and whenever outside DEMAND,
    // counting only while staying in DEMAND, sticking at all-ones.
    if ((state_q == ST_DEMAND) && (state_d == ST_DEMAND)) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      sync_q  <= '0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decode flops only, so they cannot glitch on input changes.
  assign o_detect = (state_q == ST_DEMAND) | ((state_q == ST_SERVED) & deb_q);
  assign o_wait   = wait_q;

endmodule : approach_demand

// File: rtl/vehicle_demand_detector.sv
// -----------------------------------------------------------------------------
// vehicle_demand_detector
//   Front end feeding NS_vehicle_detect / EW_vehicle_detect to the traffic
//   light controller. Two independent approach_demand channels; no
//   cross-checking between approaches.
// Ports
//   i_clk              in   1       system clock, rising edge
//   i_rst_n            in   1       synchronous reset, active low
//   i_NS_loop          in   1       raw NS loop sensor
//   i_EW_loop          in   1       raw EW loop sensor
//   i_NS_green         in   1       NS green from the controller
//   i_EW_green         in   1       EW green from the controller
//   NS_vehicle_detect  out  1       NS demand
//   EW_vehicle_detect  out  1       EW demand
//   o_NS_wait          out  WAIT_W  NS unserved wait, saturating
//   o_EW_wait          out  WAIT_W  EW unserved wait, saturating
// -----------------------------------------------------------------------------
module vehicle_demand_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WAIT_W          = WAIT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_NS_loop,
  input  logic              i_EW_loop,
  input  logic              i_NS_green,
  input  logic              i_EW_green,
  output logic              NS_vehicle_detect,
  output logic              EW_vehicle_detect,
  output logic [WAIT_W-1:0] o_NS_wait,
  output logic [WAIT_W-1:0] o_EW_wait
);

  approach_demand #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_W          (WAIT_W)
  ) u_ns (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_loop   (i_NS_loop),
    .i_green  (i_NS_green),
    .o_detect (NS_vehicle_detect),
    .o_wait   (o_NS_wait)
  );

  approach_demand #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WAIT_W          (WAIT_W)
  ) u_ew (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_loop   (i_EW_loop),
    .i_green  (i_EW_green),
    .o_detect (EW_vehicle_detect),
    .o_wait   (o_EW_wait)
  );

endmodule : vehicle_demand_detector

// File: tb/tb_vehicle_demand_detector.sv
// -----------------------------------------------------------------------------
// tb_vehicle_demand_detector
//   Directed bench for vehicle_demand_detector. A second instance with
//   WAIT_W=4 shares all inputs and is used for the saturation case.
//   Inputs change 1 time unit after a rising edge; outputs are read there.
// -----------------------------------------------------------------------------
module tb_vehicle_demand_detector;

  logic       clk;
  logic       rst_n;
  logic       ns_loop, ew_loop, ns_green, ew_green;
  logic       ns_det,  ew_det;
  logic [7:0] ns_wait, ew_wait;
  logic       ns_det4, ew_det4;
  logic [3:0] ns_wait4, ew_wait4;

  int n_checks = 0;
  int n_pass   = 0;

  vehicle_demand_detector dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_NS_loop         (ns_loop),
    .i_EW_loop         (ew_loop),
    .i_NS_green        (ns_green),
    .i_EW_green        (ew_green),
    .NS_vehicle_detect (ns_det),
    .EW_vehicle_detect (ew_det),
    .o_NS_wait         (ns_wait),
    .o_EW_wait         (ew_wait)
  );

  vehicle_demand_detector #(.DEBOUNCE_CYCLES(4), .WAIT_W(4)) dut_w4 (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_NS_loop         (ns_loop),
    .i_EW_loop         (ew_loop),
    .i_NS_green        (ns_green),
    .i_EW_green        (ew_green),
    .NS_vehicle_detect (ns_det4),
    .EW_vehicle_detect (ew_det4),
    .o_NS_wait         (ns_wait4),
    .o_EW_wait         (ew_wait4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ns_loop  = 1'b0;
    ew_loop  = 1'b0;
    ns_green = 1'b0;
    ew_green = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ns_loop  = 1'b1;
    ew_loop  = 1'b1;
    ns_green = 1'b0;
    ew_green = 1'b0;

    // 1. Reset held 3 cycles with loops high, then 7-cycle detect latency.
    step(3);
    check("rst_ns_det",  ns_det,  0);
    check("rst_ew_det",  ew_det,  0);
    check("rst_ns_wait", ns_wait, 0);
    check("rst_ew_wait", ew_wait, 0);
    rst_n = 1'b1;
    step(6);
    check("lat6_ns_det", ns_det, 0);
    check("lat6_ew_det", ew_det, 0);
    step(1);
    check("lat7_ns_det", ns_det, 1);
    check("lat7_ew_det", ew_det, 1);
    check("lat7_ns_wait", ns_wait, 0);
    step(3);
    check("both_ns_wait3", ns_wait, 3);
    check("both_ew_wait3", ew_wait, 3);

    // 2. Glitch filter: 3-cycle pulse ignored, 4-cycle pulse accepted.
    do_reset();
    ns_loop = 1'b1;
    step(3);
    ns_loop = 1'b0;
    step(10);
    check("glitch3_ns_det",  ns_det,  0);
    check("glitch3_ns_wait", ns_wait, 0);
    ns_loop = 1'b1;
    step(4);
    ns_loop = 1'b0;
    step(2);
    check("pulse4_edge6_det", ns_det, 0);
    step(1);
    check("pulse4_edge7_det", ns_det, 1);

    // 3. Latch and serve: car already gone, demand held and counting.
    step(5);
    check("latch_ns_det",  ns_det,  1);
    check("latch_ns_wait", ns_wait, 5);
    check("latch_ew_det",  ew_det,  0);
    ns_green = 1'b1;
    step(1);
    check("serve_ns_det",  ns_det,  0);
    check("serve_ns_wait", ns_wait, 0);
    ns_green = 1'b0;
    step(3);
    check("idle_ns_det",  ns_det,  0);
    check("idle_ns_wait", ns_wait, 0);

    // 4. Occupied through green: detect stays high, wait restarts at 0.
    ns_loop = 1'b1;
    step(7);
    check("occ_ns_det", ns_det, 1);
    step(2);
    check("occ_ns_wait2", ns_wait, 2);
    ns_green = 1'b1;
    step(1);
    check("occ_green_det",  ns_det,  1);
    check("occ_green_wait", ns_wait, 0);
    step(3);
    check("occ_green3_det", ns_det, 1);
    ns_green = 1'b0;
    step(1);
    check("occ_back_det",  ns_det,  1);
    check("occ_back_wait", ns_wait, 0);
    step(1);
    check("occ_back_wait1", ns_wait, 1);

    // 5. Saturation on the 4-bit instance, full count on the 8-bit one.
    do_reset();
    ew_loop = 1'b1;
    step(7);
    check("sat_ew_det4", ew_det4, 1);
    step(14);
    check("sat_ew_wait4_14", ew_wait4, 14);
    step(1);
    check("sat_ew_wait4_15", ew_wait4, 15);
    step(25);
    check("sat_ew_wait4_hold", ew_wait4, 15);
    check("sat_ew_wait8_40",   ew_wait,  40);
    check("sat_ns_idle_det",   ns_det,   0);

    // 6a. deb rises with green already high: IDLE -> SERVED, wait 0.
    do_reset();
    ew_loop = 1'b1;
    step(6);
    ew_green = 1'b1;
    step(1);
    check("simul_ew_det",  ew_det,  1);
    check("simul_ew_wait", ew_wait, 0);
    step(3);
    check("simul_ew_wait_hold", ew_wait, 0);
    ew_green = 1'b0;
    step(1);
    check("simul_back_det",  ew_det,  1);
    check("simul_back_wait", ew_wait, 0);

    // 6b. Reset mid-DEMAND clears outputs on the next cycle.
    ns_loop = 1'b1;
    step(10);
    check("mid_ns_wait3", ns_wait, 3);
    rst_n = 1'b0;
    step(1);
    check("midrst_ns_det",  ns_det,  0);
    check("midrst_ns_wait", ns_wait, 0);
    check("midrst_ew_det",  ew_det,  0);
    rst_n = 1'b1;
    step(6);
    check("midrst_relatch6", ns_det, 0);
    step(1);
    check("midrst_relatch7", ns_det, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vehicle_demand_detector
